// File: rtl/ipif_reg_master.sv
// Single-outstanding IPIF initiator: request stream in, Bus2IP_* cycle out, response stream back.
// Latency: CS rises one cycle after request acceptance; response two cycles after acceptance with a registered slave.
// Backpressure: req_ready only in IDLE; a stalled response holds the FSM in RESP with CS low.
module ipif_reg_master #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_TIMEOUT          = 255
) (
  input  logic                              Bus2IP_Clk,
  input  logic                              Bus2IP_Resetn,
  // request stream
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_rnw,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     req_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     req_data,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   req_be,
  // response stream
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     rsp_data,
  output logic                              rsp_error,
  output logic                              rsp_timeout,
  // IPIF bus
  output logic [C_S_AXI_ADDR_WIDTH-1:0]     Bus2IP_Addr,
  output logic                              Bus2IP_CS,
  output logic                              Bus2IP_RNW,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     Bus2IP_Data,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0]   Bus2IP_BE,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     IP2Bus_Data,
  input  logic                              IP2Bus_RdAck,
  input  logic                              IP2Bus_WrAck,
  input  logic                              IP2Bus_Error
);

  localparam int BE_W  = C_S_AXI_DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(C_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(C_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // run_q is part of the control state: it keeps req_ready low while reset is
  // asserted and releases it on the first edge afterwards.
  logic run_q;

  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          cs_q, cs_d;
  logic                          rnw_q, rnw_d;
  logic [C_S_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]               be_q, be_d;
  logic                          rsp_valid_q, rsp_valid_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                          rsp_error_q, rsp_error_d;
  logic                          rsp_timeout_q, rsp_timeout_d;

  logic accept;
  logic ack_ok;
  logic timeout_hit;

  // Only the ack matching the current direction completes an access; the
  // other kind is ignored so a confused slave cannot close a read with a write ack.
  assign ack_ok      = rnw_q ? IP2Bus_RdAck : IP2Bus_WrAck;
  assign timeout_hit = (cnt_q == CNT_MAX);
  assign accept      = (state_q == S_IDLE) && run_q && req_valid;

  // State register and the out-of-reset qualifier for req_ready
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      state_q <= S_IDLE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  // Next-state logic: one access in flight, response must drain before IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (ack_ok || timeout_hit) state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next-values; everything here lands in a register so
  // no IP2Bus_* input reaches an output combinationally.
  always_comb begin
    req_ready     = (state_q == S_IDLE) && run_q;
    cnt_d         = cnt_q;
    cs_d          = cs_q;
    rnw_d         = rnw_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rnw_d   = req_rnw;
          addr_d  = req_addr;
          wdata_d = req_data;
          be_d    = req_be;
          cs_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      S_ACCESS: begin
        // Saturating count; the access leaves ACCESS at CNT_MAX anyway, so
        // this only guards against wrap if that ever changes.
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (ack_ok) begin
          // Ack has priority over a timeout landing on the same cycle.
          cs_d          = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b0;
          rsp_error_d   = IP2Bus_Error;
          rsp_data_d    = rnw_q ? IP2Bus_Data : '0;
        end else if (timeout_hit) begin
          cs_d          = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_error_d   = 1'b0;
          rsp_data_d    = '0;
        end
      end
      S_RESP: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: begin
        cs_d        = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset drops CS and discards any in-flight access
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      cnt_q         <= '0;
      cs_q          <= 1'b0;
      rnw_q         <= 1'b1;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      cs_q          <= cs_d;
      rnw_q         <= rnw_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      be_q          <= be_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign Bus2IP_CS   = cs_q;
  assign Bus2IP_RNW  = rnw_q;
  assign Bus2IP_Addr = addr_q;
  assign Bus2IP_Data = wdata_q;
  assign Bus2IP_BE   = be_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_ipif_reg_master.sv
// Directed bench for ipif_reg_master with a registered register-file slave
// model, manually driven acks for protocol corner cases, and a response
// scoreboard popped on every rsp_valid/rsp_ready handshake.
module tb_ipif_reg_master;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_ready, req_rnw;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic [3:0]    req_be;
  logic          rsp_valid, rsp_ready, rsp_error, rsp_timeout;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] b_addr;
  logic          b_cs, b_rnw;
  logic [DW-1:0] b_data;
  logic [3:0]    b_be;
  logic [DW-1:0] ip_data;
  logic          ip_rdack, ip_wrack, ip_err;

  // slave model / manual ack sources
  logic          slave_en;
  logic          s_rdack, s_wrack;
  logic [DW-1:0] s_data;
  logic [DW-1:0] regs [0:15];
  logic          m_rdack, m_wrack, m_err;
  logic [DW-1:0] m_data;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          err;
    logic          to;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   rsp_count = 0;
  int   n_exp = 0;
  int   cyc;
  int   c0;

  always #5 clk = ~clk;

  ipif_reg_master #(
    .C_S_AXI_DATA_WIDTH(DW),
    .C_S_AXI_ADDR_WIDTH(AW),
    .C_TIMEOUT(TO)
  ) dut (
    .Bus2IP_Clk    (clk),
    .Bus2IP_Resetn (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_rnw       (req_rnw),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_be        (req_be),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_error     (rsp_error),
    .rsp_timeout   (rsp_timeout),
    .Bus2IP_Addr   (b_addr),
    .Bus2IP_CS     (b_cs),
    .Bus2IP_RNW    (b_rnw),
    .Bus2IP_Data   (b_data),
    .Bus2IP_BE     (b_be),
    .IP2Bus_Data   (ip_data),
    .IP2Bus_RdAck  (ip_rdack),
    .IP2Bus_WrAck  (ip_wrack),
    .IP2Bus_Error  (ip_err)
  );

  assign ip_rdack = slave_en ? s_rdack : m_rdack;
  assign ip_wrack = slave_en ? s_wrack : m_wrack;
  assign ip_data  = slave_en ? s_data  : m_data;
  assign ip_err   = slave_en ? 1'b0    : m_err;

  // Registered slave: acks one cycle after seeing CS and, because CS is still
  // high on that edge, emits a second (stale) ack the cycle after.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_rdack <= 1'b0;
      s_wrack <= 1'b0;
      s_data  <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      s_rdack <= b_cs & b_rnw;
      s_wrack <= b_cs & ~b_rnw;
      s_data  <= (b_cs & b_rnw) ? regs[b_addr[5:2]] : '0;
      if (b_cs && !b_rnw)
        for (int i = 0; i < 4; i++)
          if (b_be[i]) regs[b_addr[5:2]][8*i +: 8] <= b_data[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_rsp(input logic [DW-1:0] d, input logic e, input logic t);
    exp_t x;
    x.data = d;
    x.err  = e;
    x.to   = t;
    sb.push_back(x);
    n_exp++;
  endtask

  // Scoreboard: compare on each response handshake
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      rsp_count++;
      if (sb.size() == 0) begin
        chk("unexpected_rsp", sb.size(), 1);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_data", rsp_data, mon_e.data);
        chk("rsp_error", rsp_error, mon_e.err);
        chk("rsp_timeout", rsp_timeout, mon_e.to);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns 1 time unit after the accepting edge (e0)
  task automatic send(input logic rnw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [3:0] be);
    logic hs;
    hs = 1'b0;
    req_valid = 1'b1;
    req_rnw   = rnw;
    req_addr  = a;
    req_data  = d;
    req_be    = be;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk);
      hs = req_ready;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    chk("req_handshake", hs, 1);
  endtask

  // Cycles from acceptance until rsp_valid is visible (bounded)
  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 0; req_rnw = 0; req_addr = '0; req_data = '0; req_be = '0;
    rsp_ready = 1; slave_en = 1;
    m_rdack = 0; m_wrack = 0; m_err = 0; m_data = '0;

    // reset state
    #12;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_error", rsp_error, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_cs", b_cs, 0);
    chk("rst_rnw", b_rnw, 1);
    chk("rst_addr", b_addr, 0);
    chk("rst_data", b_data, 0);
    chk("rst_be", b_be, 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    chk("req_ready_after_rst", req_ready, 1);

    // write then read through the registered slave
    expect_rsp(32'h0, 0, 0);
    send(0, 32'h04, 32'hA5A5_0001, 4'hF);
    chk("wr_cs_high", b_cs, 1);
    chk("wr_addr", b_addr, 32'h04);
    chk("wr_rnw", b_rnw, 0);
    chk("wr_bus_data", b_data, 32'hA5A5_0001);
    wait_rsp(cyc);
    chk("wr_latency", cyc, 2);
    chk("wr_cs_low_at_rsp", b_cs, 0);
    tick();
    expect_rsp(32'hA5A5_0001, 0, 0);
    send(1, 32'h04, 32'h0, 4'hF);
    chk("rd_rnw", b_rnw, 1);
    wait_rsp(cyc);
    chk("rd_latency", cyc, 2);
    tick();
    chk("addr_hold_idle", b_addr, 32'h04);

    // backpressure on a read response
    expect_rsp(32'h0, 0, 0);
    send(0, 32'h08, 32'h1234_5678, 4'hF);
    wait_rsp(cyc);
    tick();
    rsp_ready = 0;
    expect_rsp(32'h1234_5678, 0, 0);
    send(1, 32'h08, 32'h0, 4'hF);
    wait_rsp(cyc);
    chk("bp_latency", cyc, 2);
    req_valid = 1; req_rnw = 0; req_addr = 32'h3C; req_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data", rsp_data, 32'h1234_5678);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_cs", b_cs, 0);
      tick();
    end
    chk("bp_addr_unchanged", b_addr, 32'h08);
    req_valid = 0;
    c0 = rsp_count;
    rsp_ready = 1;
    tick();
    chk("bp_rsp_dropped", rsp_valid, 0);
    chk("bp_one_rsp", rsp_count - c0, 1);

    // wrong-type ack during a read, then RdAck with error
    slave_en = 0;
    rsp_ready = 0;
    expect_rsp(32'hDEAD_BEEF, 1, 0);
    send(1, 32'h10, 32'h0, 4'hF);
    m_wrack = 1;
    tick();
    m_wrack = 0;
    chk("wt_no_rsp", rsp_valid, 0);
    chk("wt_cs_held", b_cs, 1);
    tick();
    tick();
    m_rdack = 1; m_err = 1; m_data = 32'hDEAD_BEEF;
    tick();
    m_rdack = 0; m_err = 0;
    chk("wt_rsp_valid", rsp_valid, 1);
    chk("wt_cs_low", b_cs, 0);
    // stale acks while in RESP, then in IDLE
    m_rdack = 1; m_wrack = 1; m_err = 1; m_data = 32'h1111_1111;
    tick();
    tick();
    chk("stale_resp_data", rsp_data, 32'hDEAD_BEEF);
    chk("stale_resp_err", rsp_error, 1);
    c0 = rsp_count;
    rsp_ready = 1;
    tick();
    tick();
    tick();
    m_rdack = 0; m_wrack = 0; m_err = 0;
    chk("stale_one_rsp", rsp_count - c0, 1);
    chk("stale_rsp_valid", rsp_valid, 0);
    chk("stale_cs", b_cs, 0);

    // timeout with no ack
    expect_rsp(32'h0, 0, 1);
    send(1, 32'h20, 32'h0, 4'hF);
    wait_rsp(cyc);
    chk("to_latency", cyc, TO + 1);
    chk("to_cs_low", b_cs, 0);
    chk("to_req_ready", req_ready, 0);
    tick();

    // ack on the same cycle the counter reaches the timeout value
    m_data = 32'hCAFE_0004;
    expect_rsp(32'hCAFE_0004, 0, 0);
    send(1, 32'h24, 32'h0, 4'hF);
    repeat (TO) tick();
    chk("bnd_cs_high", b_cs, 1);
    chk("bnd_no_rsp_yet", rsp_valid, 0);
    m_rdack = 1;
    tick();
    m_rdack = 0;
    chk("bnd_rsp_valid", rsp_valid, 1);
    chk("bnd_cs_low", b_cs, 0);
    tick();

    // asynchronous reset in the middle of an access
    send(0, 32'h28, 32'h0BAD_0BAD, 4'hF);
    chk("mid_cs_high", b_cs, 1);
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_cs", b_cs, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    tick();
    chk("post_rst_req_ready", req_ready, 1);
    slave_en = 1;
    expect_rsp(32'h0, 0, 0);
    send(0, 32'h0C, 32'h55AA_55AA, 4'hF);
    wait_rsp(cyc);
    chk("post_rst_wr_latency", cyc, 2);
    tick();
    // partial byte enables reach the slave unchanged
    expect_rsp(32'h0, 0, 0);
    send(0, 32'h0C, 32'hFFFF_FFFF, 4'b0011);
    chk("be_bus", b_be, 4'b0011);
    wait_rsp(cyc);
    tick();
    expect_rsp(32'h55AA_FFFF, 0, 0);
    send(1, 32'h0C, 32'h0, 4'hF);
    wait_rsp(cyc);
    chk("post_rst_rd_latency", cyc, 2);
    tick();

    repeat (3) tick();
    chk("sb_drained", sb.size(), 0);
    chk("rsp_count", rsp_count, n_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ipif_reg_master.md
# ipif_reg_master

Single-outstanding IPIF bus initiator that turns a valid/ready register-access request stream into Bus2IP_* cycles toward IPIF register slaves, and returns read data and completion status on a valid/ready response stream. It sits between an on-chip controller (e.g. a config sequencer or debug bridge) and one or more `ipif_regs`-style register files. It provides a per-access ack timeout so that a missing or non-responding slave cannot hang the controller.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, data width of the bus and of the request/response streams.
- C_S_AXI_ADDR_WIDTH, 32, address width.
- C_TIMEOUT, 255, number of cycles `Bus2IP_CS` may stay high without a matching ack before the access is abandoned. Must be at least 2.

Ports:
- Bus2IP_Clk, in, 1, the only clock.
- Bus2IP_Resetn, in, 1, reset, asynchronous, active-low.
- req_valid, in, 1, request present.
- req_ready, out, 1, request accepted this cycle when high together with req_valid.
- req_rnw, in, 1, 1 = read, 0 = write.
- req_addr, in, C_S_AXI_ADDR_WIDTH, byte address.
- req_data, in, C_S_AXI_DATA_WIDTH, write data.
- req_be, in, C_S_AXI_DATA_WIDTH/8, byte enables.
- rsp_valid, out, 1, response present.
- rsp_ready, in, 1, response consumed.
- rsp_data, out, C_S_AXI_DATA_WIDTH, read data. Zero for writes and timeouts.
- rsp_error, out, 1, slave reported IP2Bus_Error with the ack.
- rsp_timeout, out, 1, no ack within C_TIMEOUT cycles.
- Bus2IP_Addr, out, C_S_AXI_ADDR_WIDTH, access address.
- Bus2IP_CS, out, 1, chip select; held high until the access completes.
- Bus2IP_RNW, out, 1, read/not-write.
- Bus2IP_Data, out, C_S_AXI_DATA_WIDTH, write data.
- Bus2IP_BE, out, C_S_AXI_DATA_WIDTH/8, byte enables.
- IP2Bus_Data, in, C_S_AXI_DATA_WIDTH, read data, valid with IP2Bus_RdAck.
- IP2Bus_RdAck, in, 1, read acknowledge.
- IP2Bus_WrAck, in, 1, write acknowledge.
- IP2Bus_Error, in, 1, error qualifier, sampled only with the accepted ack.

## Operation
- **FSM states:** IDLE, ACCESS, RESP.
- **IDLE:**
  - req_ready = 1.
  - On req_valid, latch rnw/addr/data/be into the Bus2IP_* output registers, set Bus2IP_CS = 1, clear the timeout counter, and go to ACCESS.
- **ACCESS:**
  - req_ready = 0 and CS = 1.
  - The counter increments every cycle.
  - **Accepted ack:** IP2Bus_RdAck when RNW = 1, or IP2Bus_WrAck when RNW = 0.
    - Capture IP2Bus_Data (reads only; writes capture 0) and IP2Bus_Error.
    - CS <= 0, rsp_valid <= 1, rsp_timeout <= 0.
    - Go to RESP.
  - **Non-matching ack type:** ignored; keep waiting.
  - **Timeout:** when the counter reaches C_TIMEOUT with no accepted ack:
    - CS <= 0, rsp_valid <= 1, rsp_timeout <= 1, rsp_error <= 0, rsp_data <= 0.
    - Go to RESP.
  - **Ack and timeout on the same cycle:** the ack wins (normal completion).
- **RESP:**
  - Hold rsp_* stable while rsp_valid && !rsp_ready.
  - On rsp_ready, rsp_valid <= 0 and go to IDLE.
  - The next access cannot assert CS before IDLE is re-entered. This guarantees at least 2 cycles of CS low between accesses.
- **Stale acks:** any ack sampled outside ACCESS is discarded. This covers registered slaves, which emit one extra ack because CS was still high on the edge where the first ack was sampled. A held CS may cause a slave to re-write the same data; that is idempotent and accepted.
- **Bus outputs:** Bus2IP_Addr/RNW/Data/BE stay constant from the CS rising edge until CS falls. They hold their last value while idle.
- **Counter:** width is the ceiling of log2(C_TIMEOUT+1). It saturates and never wraps.

## Timing
- **Reset:** asynchronous assertion forces immediately:
  - state = IDLE; req_ready = 0 while in reset, 1 from the first edge after release;
  - rsp_valid = 0, rsp_data = 0, rsp_error = 0, rsp_timeout = 0;
  - Bus2IP_CS = 0, Bus2IP_RNW = 1, Bus2IP_Addr = 0, Bus2IP_Data = 0, Bus2IP_BE = 0;
  - counter = 0.
- **Reset mid-access:** CS drops immediately, no response is produced, and the in-flight request is lost.
- **Handshake timing:** request accepted at edge e0 → CS high after e0.
- **Against a one-cycle registered slave:**
  - the ack is high after e1 and sampled at e2;
  - rsp_valid is high and CS low after e2;
  - request-to-response latency is 2 cycles.
- **Throughput:** with rsp_ready held high, RESP lasts 1 cycle and IDLE 1 cycle. Back-to-back accesses occupy 4 cycles each.
- **Timeout:** if no ack arrives, rsp_valid rises C_TIMEOUT+1 cycles after e0.
- **Combinational paths:** req_ready depends only on state. No combinational path exists from IP2Bus_* to any output.

## Test plan
- **Write then read:** attach an ipif_regs-style slave (1 WO, 8 RW, 10 RO). Write 0xA5A5_0001 to addr 0x04, then read addr 0x04. Required: rsp_data = 0xA5A5_0001, rsp_error = 0, rsp_timeout = 0, latency 2 cycles each.
- **Timeout:** C_TIMEOUT = 8, no slave (acks tied 0). Required: rsp_valid 9 cycles after acceptance, rsp_timeout = 1, rsp_data = 0, CS low for the response cycle onward.
- **Backpressure:** hold rsp_ready = 0 for 5 cycles after a read of 0x1234_5678. Required: rsp_* stable, req_ready = 0, CS = 0 and no new access during the stall; one response only.
- **Wrong-type and stale ack:** slave pulses IP2Bus_WrAck during a read, then RdAck 3 cycles later with IP2Bus_Error = 1. Required: completion on RdAck only, rsp_error = 1. Also, extra acks injected in RESP/IDLE produce no response.
- **Ack at timeout boundary:** with C_TIMEOUT = 4, assert RdAck on the cycle the counter hits 4. Required: rsp_timeout = 0, rsp_data = IP2Bus_Data.
- **Reset mid-access:** deassert Bus2IP_Resetn asynchronously while CS = 1. Required: CS = 0 and rsp_valid = 0 before the next clock edge; after release, a new write completes normally.
